// File: rtl/serpent_round_ctrl_pkg.sv
// Shared definitions for the Serpent round controller: FSM states, sizing constants
// and the initial bit permutation used when a block is loaded.
package serpent_round_ctrl_pkg;

   localparam int ROUNDS_DEF = 32;
   localparam int KEY_IDX_W  = 6;
   localparam int BLK_W      = 128;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ROUND = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

   // Bitslice layout: output nibble i gathers bit i of each of the four 32-bit words.
   function automatic logic [BLK_W-1:0] serpent_ip(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) begin
            y[4*i+j] = x[32*j+i];
         end
      end
      return y;
   endfunction

endpackage

// File: rtl/Serpent_FP.sv
// Serpent final permutation, the exact inverse of serpent_ip; pure wiring, no state.
module Serpent_FP
   import serpent_round_ctrl_pkg::*;
(
   input  logic [BLK_W-1:0] i_data,
   output logic [BLK_W-1:0] o_data
);

   for (genvar i = 0; i < 32; i++) begin : g_bit
      for (genvar j = 0; j < 4; j++) begin : g_word
         assign o_data[32*j+i] = i_data[4*i+j];
      end
   end

endmodule

// File: rtl/serpent_round_ctrl.sv
// Serpent round sequencer: IP on accept, ROUNDS iterations through an external datapath, FP on output.
// Latency ROUNDS edges accept-to-valid; output held under i_ready=0, no input taken outside IDLE.
module serpent_round_ctrl
   import serpent_round_ctrl_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [BLK_W-1:0]     i_data,
   output logic [BLK_W-1:0]     o_round_in,
   input  logic [BLK_W-1:0]     i_round_out,
   output logic [KEY_IDX_W-1:0] o_key_idx,
   output logic                 o_last,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [BLK_W-1:0]     o_data,
   output logic                 o_busy
);

   localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(ROUNDS - 1);

   state_t               state_q, state_d;
   logic [KEY_IDX_W-1:0] cnt_q,   cnt_d;
   logic [BLK_W-1:0]     blk_q,   blk_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               blk_d   = serpent_ip(i_data);
               cnt_d   = '0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            blk_d = i_round_out;
            // Counter parks on the last index so DONE still reports it.
            if (cnt_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + KEY_IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
      end
   end

   assign o_ready    = (state_q == ST_IDLE);
   assign o_valid    = (state_q == ST_DONE);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_last     = (state_q == ST_ROUND) && (cnt_q == LAST_IDX);
   assign o_round_in = blk_q;
   assign o_key_idx  = cnt_q;

   Serpent_FP u_fp (
      .i_data (blk_q),
      .o_data (o_data)
   );

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Bench for serpent_round_ctrl: stub round datapath plus a word/nibble-level reference model.
module tb_serpent_round_ctrl;

   localparam int R = 32;
   localparam logic [127:0] LAST_KEY = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic [127:0] o_round_in;
   logic [127:0] i_round_out;
   logic [5:0]   o_key_idx;
   logic         o_last;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;
   logic         o_busy;
   logic [1:0]   stub_mode;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   serpent_round_ctrl #(.ROUNDS(R)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .o_round_in  (o_round_in),
      .i_round_out (i_round_out),
      .o_key_idx   (o_key_idx),
      .o_last      (o_last),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_busy      (o_busy)
   );

   // External round datapath stand-in; mode 2 keys off o_key_idx and o_last.
   always_comb begin
      i_round_out = o_round_in;
      case (stub_mode)
         2'd0:    i_round_out = o_round_in;
         2'd1:    i_round_out = o_round_in + 128'd1;
         default: i_round_out = {o_round_in[126:0], o_round_in[127]}
                                ^ {4{26'h1234567, o_key_idx}}
                                ^ (o_last ? LAST_KEY : 128'd0);
      endcase
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] m_ip(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int n = 0; n < 32; n++) y[4*n +: 4] = {x[96+n], x[64+n], x[32+n], x[n]};
      return y;
   endfunction

   function automatic logic [127:0] m_fp(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int n = 0; n < 32; n++) begin
         y[n]    = x[4*n];
         y[32+n] = x[4*n+1];
         y[64+n] = x[4*n+2];
         y[96+n] = x[4*n+3];
      end
      return y;
   endfunction

   function automatic logic [127:0] m_encrypt(input logic [127:0] x, input int mode);
      logic [127:0] s;
      s = m_ip(x);
      for (int k = 0; k < R; k++) begin
         if (mode == 1) s = s + 128'd1;
         else if (mode == 2)
            s = {s[126:0], s[127]} ^ {4{26'h1234567, 6'(k)}} ^ ((k == R-1) ? LAST_KEY : 128'd0);
      end
      return m_fp(s);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_block(input logic [127:0] d, input int hold,
                             output logic [127:0] got, output int lat);
      i_data  = d;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_data  = rnd128();
      lat = 0;
      while (!o_valid && lat < 200) begin
         tick();
         lat++;
      end
      repeat (hold) tick();
      got = o_data;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] got, d, exp;
      int lat, cnt_v, cnt_nr, n_out;
      logic [127:0] exp_q[$];
      int acc_t[$];

      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; stub_mode = 2'd0;
      #12;
      chk("rst_ready",    128'(o_ready),    128'd1);
      chk("rst_valid",    128'(o_valid),    128'd0);
      chk("rst_busy",     128'(o_busy),     128'd0);
      chk("rst_last",     128'(o_last),     128'd0);
      chk("rst_key_idx",  128'(o_key_idx),  128'd0);
      chk("rst_round_in", o_round_in,       128'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      chk("idle_ready", 128'(o_ready), 128'd1);

      // Identity datapath: FP(IP(x)) must return x after exactly R edges.
      stub_mode = 2'd0;
      d = 128'h0123456789ABCDEF_FEDCBA9876543210;
      send_block(d, 0, got, lat);
      chk("id_latency", 128'(lat), 128'(R));
      chk("id_data",    got,       d);
      chk("id_ready_after", 128'(o_ready), 128'd1);

      // Increment datapath: key index walk and last-round flag.
      stub_mode = 2'd1;
      i_data = '0; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      for (int k = 0; k < R; k++) begin
         chk("inc_key_idx", 128'(o_key_idx), 128'(k));
         chk("inc_last",    128'(o_last),    128'(k == R-1));
         tick();
      end
      chk("inc_valid",    128'(o_valid),   128'd1);
      chk("inc_data",     o_data,          m_fp(128'd32));
      chk("done_key_idx", 128'(o_key_idx), 128'(R-1));
      chk("done_last",    128'(o_last),    128'd0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("idle_key_idx", 128'(o_key_idx), 128'd0);

      // Keyed datapath with random data and random consumer stalls.
      stub_mode = 2'd2;
      repeat (6) begin
         d = rnd128();
         send_block(d, int'($urandom_range(0, 5)), got, lat);
         chk("rnd_latency", 128'(lat), 128'(R));
         chk("rnd_data",    got,       m_encrypt(d, 2));
      end

      // Backpressure in DONE with an ignored i_valid pulse.
      d = rnd128();
      exp = m_encrypt(d, 2);
      i_data = d; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk("bp_latency", 128'(lat), 128'(R));
      for (int c = 0; c < 10; c++) begin
         chk("bp_valid", 128'(o_valid), 128'd1);
         chk("bp_data",  o_data,        exp);
         chk("bp_ready", 128'(o_ready), 128'd0);
         if (c == 4) begin
            i_valid = 1'b1;
            i_data  = rnd128();
         end else begin
            i_valid = 1'b0;
         end
         tick();
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("bp_ready_after", 128'(o_ready), 128'd1);
      chk("bp_valid_after", 128'(o_valid), 128'd0);
      tick();
      chk("bp_no_buffer", 128'(o_busy), 128'd0);

      // Asynchronous reset in the middle of round 15.
      i_data = rnd128(); i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (15) tick();
      chk("mid_key_idx", 128'(o_key_idx), 128'd15);
      chk("mid_busy",    128'(o_busy),    128'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_ready",    128'(o_ready),   128'd1);
      chk("arst_valid",    128'(o_valid),   128'd0);
      chk("arst_busy",     128'(o_busy),    128'd0);
      chk("arst_last",     128'(o_last),    128'd0);
      chk("arst_key_idx",  128'(o_key_idx), 128'd0);
      chk("arst_round_in", o_round_in,      128'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      cnt_v = 0; cnt_nr = 0;
      repeat (50) begin
         tick();
         if (o_valid) cnt_v++;
         if (!o_ready) cnt_nr++;
      end
      chk("arst_no_valid",  128'(cnt_v),  128'd0);
      chk("arst_ready_hold", 128'(cnt_nr), 128'd0);

      // Back-to-back traffic with both handshakes tied high.
      i_valid = 1'b1; i_ready = 1'b1; i_data = rnd128();
      n_out = 0;
      for (int cyc = 0; cyc < 34*5 + 10; cyc++) begin
         if (o_ready) begin
            exp_q.push_back(m_encrypt(i_data, 2));
            acc_t.push_back(cyc);
         end
         if (o_valid) begin
            n_out++;
            if (exp_q.size() == 0) chk("b2b_spurious", 128'd1, 128'd0);
            else chk("b2b_data", o_data, exp_q.pop_front());
         end
         tick();
         i_data = rnd128();
      end
      i_valid = 1'b0;
      for (int a = 1; a < acc_t.size(); a++)
         chk("b2b_gap", 128'(acc_t[a] - acc_t[a-1]), 128'd34);
      chk("b2b_accepts", 128'(acc_t.size()), 128'd6);
      chk("b2b_outputs", 128'(n_out),        128'd5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
